// File: rtl/dtt_xbar_ingress_scheduler.sv
// dtt_xbar_ingress_scheduler
// Ingress stage in front of the dtt crossbar. Each source lane is buffered in
// its own FIFO, and one round-robin arbiter per crossbar output picks at most
// one head per output each cycle. The registered xb_* lanes therefore never
// present two valid beats with the same destination.
//
// Optional feature: define DTT_SCHED_STATS_EN to build the per-input saturating
// backpressure counters (stall_cnt). Without it, stall_cnt is tied to zero.
//
// A beat written at edge t becomes eligible for arbitration one cycle later
// (edge t+1), so the earliest it can reach xb_valid is edge t+2. "count" tracks
// total occupancy (drives s_ready); "avail" tracks entries that may be granted.

module dtt_xbar_ingress_scheduler #(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = $clog2(N_OUT),
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data    [N_IN],
  input  logic [DEST_WIDTH-1:0] s_dest    [N_IN],
  input  logic                  s_valid   [N_IN],
  output logic                  s_ready   [N_IN],
  output logic [DATA_WIDTH-1:0] xb_data   [N_IN],
  output logic [DEST_WIDTH-1:0] xb_dest   [N_IN],
  output logic                  xb_valid  [N_IN],
  output logic [15:0]           stall_cnt [N_IN]
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit DEST_POW2 = ((1 << DEST_WIDTH) == N_OUT);

  logic [AW-1:0]         wr_ptr    [N_IN];
  logic [AW-1:0]         rd_ptr    [N_IN];
  logic [CW-1:0]         count     [N_IN];
  logic [CW-1:0]         avail     [N_IN];
  logic                  push      [N_IN];
  logic                  push_d    [N_IN];
  logic                  pop       [N_IN];
  logic [DATA_WIDTH-1:0] head_data [N_IN];
  logic [DEST_WIDTH-1:0] head_dest [N_IN];

  logic [PW-1:0]         rr_ptr    [N_OUT];
  logic                  gnt_any   [N_OUT];
  logic [PW-1:0]         gnt_idx   [N_OUT];

  for (genvar i = 0; i < N_IN; i++) begin : g_lane
    logic                  dest_ok;
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [DEST_WIDTH-1:0] mem_dest [DEPTH];

    assign dest_ok      = DEST_POW2 || (32'(s_dest[i]) < 32'(N_OUT));
    assign s_ready[i]   = rst_n && (count[i] < FULL_CNT);
    assign push[i]      = s_valid[i] && s_ready[i] && dest_ok;
    assign head_data[i] = mem_data[rd_ptr[i]];
    assign head_dest[i] = mem_dest[rd_ptr[i]];

    // FIFO storage: write the accepted beat at the write pointer
    always_ff @(posedge clk) begin
      if (push[i]) begin
        mem_data[wr_ptr[i]] <= s_data[i];
        mem_dest[wr_ptr[i]] <= s_dest[i];
      end
    end
  end

  // FIFO pointers, occupancy and grant-eligible count for every lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        avail[i]  <= '0;
        push_d[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        push_d[i] <= push[i];
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
        if (push_d[i] && !pop[i])      avail[i] <= avail[i] + 1'b1;
        else if (!push_d[i] && pop[i]) avail[i] <= avail[i] - 1'b1;
      end
    end
  end

  // Per-output round-robin arbiters; each granted head pops this cycle
  always_comb begin : arb
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_IN; i++) pop[i] = 1'b0;
    for (int o = 0; o < N_OUT; o++) begin
      found      = 1'b0;
      gnt_any[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = 0; k < N_IN; k++) begin
        idx = int'(rr_ptr[o]) + k;
        if (idx >= N_IN) idx = idx - N_IN;
        if (!found && (avail[idx] != '0) && (head_dest[idx] == DEST_WIDTH'(o))) begin
          found      = 1'b1;
          gnt_any[o] = 1'b1;
          gnt_idx[o] = PW'(idx);
          pop[idx]   = 1'b1;
        end
      end
    end
  end

  // Round-robin pointers move just past the winner; idle outputs hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < N_OUT; o++) rr_ptr[o] <= '0;
    end else begin
      for (int o = 0; o < N_OUT; o++) begin
        if (gnt_any[o]) begin
          rr_ptr[o] <= (gnt_idx[o] == PW'(N_IN - 1)) ? '0 : gnt_idx[o] + 1'b1;
        end
      end
    end
  end

  // Registered crossbar lanes; non-granted lanes drop valid and keep payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        xb_valid[i] <= 1'b0;
        xb_data[i]  <= '0;
        xb_dest[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        xb_valid[i] <= pop[i];
        if (pop[i]) begin
          xb_data[i] <= head_data[i];
          xb_dest[i] <= head_dest[i];
        end
      end
    end
  end

`ifdef DTT_SCHED_STATS_EN
  // Saturating count of cycles where a source offers a beat but is refused
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) stall_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (s_valid[i] && !s_ready[i] && (stall_cnt[i] != 16'hFFFF)) begin
          stall_cnt[i] <= stall_cnt[i] + 16'd1;
        end
      end
    end
  end
`else
  for (genvar i = 0; i < N_IN; i++) begin : g_no_stats
    assign stall_cnt[i] = '0;
  end
`endif

endmodule

// File: tb/tb_dtt_xbar_ingress_scheduler.sv
// tb_dtt_xbar_ingress_scheduler
// Self-checking bench: a queue-based reference model acts as the scoreboard
// (beats are queued when driven and popped when the DUT should issue them),
// a table of short single-cycle bursts checks latency and arbitration order,
// and hand sequences cover full conflict, backpressure and mid-run reset.

module tb_dtt_xbar_ingress_scheduler;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TW    = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] dest;
    int            t_push;
  } beat_t;

  typedef struct {
    logic [N-1:0]         valid;
    logic [N-1:0][TW-1:0] dest;
    logic [N-1:0]         exp_t1;
    logic [N-1:0]         exp_t2;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data    [N];
  logic [TW-1:0] s_dest    [N];
  logic          s_valid   [N];
  logic          s_ready   [N];
  logic [DW-1:0] xb_data   [N];
  logic [TW-1:0] xb_dest   [N];
  logic          xb_valid  [N];
  logic [15:0]   stall_cnt [N];

  int total = 0;
  int bad   = 0;
  int seq   = 0;
  int ecount = 0;

  beat_t         mq [N][$];
  int            rr [N];
  logic          exp_valid [N];
  logic [DW-1:0] exp_data  [N];
  logic [TW-1:0] exp_dest  [N];
  int            exp_stall [N];

  vec_t vecs [6];

  dtt_xbar_ingress_scheduler #(
    .N_IN(N), .N_OUT(4), .DATA_WIDTH(DW), .DEST_WIDTH(TW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_data(s_data),
    .s_dest(s_dest),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .xb_data(xb_data),
    .xb_dest(xb_dest),
    .xb_valid(xb_valid),
    .stall_cnt(stall_cnt)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time bound so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string what, input int lane,
                              input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s lane=%0d got=%0h want=%0h", what, lane, act, want);
    end
  endtask

  function automatic logic [N-1:0] valid_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = xb_valid[i];
    return m;
  endfunction

  // Reference model advanced once per active clock edge
  task automatic model_step();
    logic  gr  [N];
    logic  rdy [N];
    beat_t b;
    int    idx;
    bit    found;
    ecount++;
    for (int i = 0; i < N; i++) begin
      gr[i]  = 1'b0;
      rdy[i] = (mq[i].size() < DEPTH);
    end
    for (int o = 0; o < 4; o++) begin
      int start;
      start = rr[o];
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (start + k) % N;
        if (!found && mq[idx].size() > 0 && (ecount - mq[idx][0].t_push) >= 2 &&
            int'(mq[idx][0].dest) == o) begin
          found   = 1'b1;
          gr[idx] = 1'b1;
          rr[o]   = (idx + 1) % N;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (gr[i]) begin
        b = mq[i].pop_front();
        exp_valid[i] = 1'b1;
        exp_data[i]  = b.data;
        exp_dest[i]  = b.dest;
      end else begin
        exp_valid[i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (s_valid[i]) begin
        if (rdy[i]) mq[i].push_back('{data: s_data[i], dest: s_dest[i], t_push: ecount});
        else if (exp_stall[i] < 65535) exp_stall[i]++;
      end
    end
  endtask

  task automatic check_cycle();
    logic dup;
    int   want_stall;
    dup = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_output("s_ready",  i, 32'(s_ready[i]), 32'(mq[i].size() < DEPTH));
      check_output("xb_valid", i, 32'(xb_valid[i]), 32'(exp_valid[i]));
      check_output("xb_data",  i, xb_data[i], exp_data[i]);
      check_output("xb_dest",  i, 32'(xb_dest[i]), 32'(exp_dest[i]));
`ifdef DTT_SCHED_STATS_EN
      want_stall = exp_stall[i];
`else
      want_stall = 0;
`endif
      check_output("stall_cnt", i, 32'(stall_cnt[i]), 32'(want_stall));
    end
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        if (xb_valid[a] && xb_valid[b] && xb_dest[a] == xb_dest[b]) dup = 1'b1;
    check_output("distinct_dest", 0, 32'(dup), 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic apply_stimulus(input logic [N-1:0] valid, input logic [N-1:0][TW-1:0] dest);
    for (int i = 0; i < N; i++) begin
      s_valid[i] = valid[i];
      s_dest[i]  = dest[i];
      s_data[i]  = {8'(i), 24'(seq)};
      seq++;
    end
  endtask

  task automatic idle(input int n);
    apply_stimulus('0, '0);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_valid[i] = 1'b1;
      s_dest[i]  = TW'(i);
      s_data[i]  = $urandom;
    end
    repeat (n) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_output("rst_valid", i, 32'(xb_valid[i]), 32'd0);
      check_output("rst_data",  i, xb_data[i], 32'd0);
      check_output("rst_dest",  i, 32'(xb_dest[i]), 32'd0);
      check_output("rst_ready", i, 32'(s_ready[i]), 32'd0);
      check_output("rst_stall", i, 32'(stall_cnt[i]), 32'd0);
    end
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      rr[i]        = 0;
      exp_valid[i] = 1'b0;
      exp_data[i]  = '0;
      exp_dest[i]  = '0;
      exp_stall[i] = 0;
      s_valid[i]   = 1'b0;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt3;
    int single;
    logic [N-1:0] m;

    vecs[0] = '{4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000, 4'b0001};
    vecs[1] = '{4'b1111, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000, 4'b1111};
    vecs[2] = '{4'b0110, {2'd0, 2'd1, 2'd1, 2'd0}, 4'b0000, 4'b0010};
    vecs[3] = '{4'b1001, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 4'b0001};
    vecs[4] = '{4'b1010, {2'd2, 2'd0, 2'd3, 2'd0}, 4'b0000, 4'b1010};
    vecs[5] = '{4'b0101, {2'd0, 2'd2, 2'd0, 2'd2}, 4'b0000, 4'b0001};

    for (int i = 0; i < N; i++) begin
      s_valid[i] = 1'b0;
      s_data[i]  = '0;
      s_dest[i]  = '0;
    end

    $display("[TB] reset and single-cycle burst table");
    do_reset(3);
    cycle();
    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].valid, vecs[v].dest);
      if (v == 0) s_data[0] = 32'hA5A5_0001;
      cycle();
      apply_stimulus('0, '0);
      cycle();
      check_output("vec_t1", v, 32'(valid_mask()), 32'(vecs[v].exp_t1));
      cycle();
      check_output("vec_t2", v, 32'(valid_mask()), 32'(vecs[v].exp_t2));
      if (v == 0) begin
        check_output("single_data", 0, xb_data[0], 32'hA5A5_0001);
        check_output("single_dest", 0, 32'(xb_dest[0]), 32'd2);
      end
      repeat (4) cycle();
    end

    $display("[TB] full conflict on output 1");
    do_reset(2);
    cycle();
    apply_stimulus(4'b1111, {2'd1, 2'd1, 2'd1, 2'd1});
    cycle();
    apply_stimulus('0, '0);
    cycle();
    check_output("conflict_t1", 0, 32'(valid_mask()), 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check_output("conflict_order", k, 32'(valid_mask()), 32'(1 << k));
    end
    apply_stimulus(4'b1010, {2'd1, 2'd1, 2'd1, 2'd1});
    cycle();
    apply_stimulus('0, '0);
    cycle();
    cycle();
    check_output("rr_wrap_first", 1, 32'(valid_mask()), 32'b0010);
    cycle();
    check_output("rr_wrap_second", 3, 32'(valid_mask()), 32'b1000);
    idle(2);

    $display("[TB] backpressure, all inputs streaming to output 0");
    do_reset(2);
    cycle();
    cnt3   = 0;
    single = 0;
    for (int c = 0; c < 40; c++) begin
      apply_stimulus(4'b1111, {2'd0, 2'd0, 2'd0, 2'd0});
      cycle();
      if (c >= 12 && c < 32) begin
        m = valid_mask();
        if ($countones(m) == 1) single++;
        if (m[3]) cnt3++;
      end
    end
    check_output("bp_one_grant_per_cycle", 0, 32'(single), 32'd20);
    check_output("bp_lane3_every_4th", 3, 32'(cnt3), 32'd5);
    idle(24);

    $display("[TB] reset in the middle of traffic");
    do_reset(2);
    cycle();
    apply_stimulus(4'b1111, {2'd0, 2'd0, 2'd0, 2'd0});
    cycle();
    apply_stimulus(4'b1111, {2'd0, 2'd0, 2'd0, 2'd0});
    cycle();
    idle(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check_output("async_clear_valid", i, 32'(xb_valid[i]), 32'd0);
      check_output("async_clear_ready", i, 32'(s_ready[i]), 32'd0);
    end
    do_reset(2);
    single = 0;
    for (int c = 0; c < 12; c++) begin
      idle(1);
      if (valid_mask() != '0) single++;
    end
    check_output("no_stale_beats", 0, 32'(single), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dtt_xbar_ingress_scheduler.md
Name: dtt_xbar_ingress_scheduler

Overview:
- Ingress stage directly upstream of the dtt crossbar switch.
- Buffers each source in a per-input FIFO and runs one round-robin arbiter per output.
- Each cycle it presents a conflict-free set of (data, dest, valid) to the crossbar's in_* ports: no two asserted xb_valid lanes share a destination.
- Gives upstream sources a valid/ready interface in place of the crossbar's silent last-writer-wins collision behaviour.

Parameters:
- N_IN, 4, number of source/input lanes
- N_OUT, 4, number of crossbar outputs
- DATA_WIDTH, 32, payload width
- DEST_WIDTH, $clog2(N_OUT), destination index width
- DEPTH, 4, per-input FIFO entries; power of 2, >=2

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s_data[N_IN]  input  DATA_WIDTH  source payload
- s_dest[N_IN]  input  DEST_WIDTH  source destination output index
- s_valid[N_IN]  input  1  source beat valid
- s_ready[N_IN]  output  1  FIFO can accept a beat
- xb_data[N_IN]  output  DATA_WIDTH  to crossbar in_data[i]
- xb_dest[N_IN]  output  DEST_WIDTH  to crossbar in_dest[i]
- xb_valid[N_IN]  output  1  to crossbar in_valid[i]
- stall_cnt[N_IN]  output  16  per-input backpressure counter (optional feature)

Behaviour:
- Reset (async assert, sync-to-clk release):
  - FIFOs empty, all rr_ptr = 0.
  - xb_valid = 0, xb_data = 0, xb_dest = 0, stall_cnt = 0.
  - s_ready = 0 while rst_n is low.
- Push: a beat is accepted on a rising edge when s_valid[i] && s_ready[i].
- s_ready[i] = rst_n && (count[i] < DEPTH). It depends only on current occupancy, so a full FIFO accepts no push even in a cycle where it pops.
- A pushed beat is at the FIFO head on the next cycle.
- Request: input i requests output o when its FIFO is non-empty and head.dest == o. Each input requests exactly one output, so each input receives at most one grant.
- Arbiter per output o (combinational):
  - Scan i = rr_ptr[o], rr_ptr[o]+1, ... mod N_IN; grant the first requester g.
  - On a grant, rr_ptr[o] <= (g+1) mod N_IN at the clock edge. With no grant, rr_ptr[o] is unchanged.
- Pop/issue: every granted head pops in the same cycle.
  - Registered outputs: xb_valid[g] <= 1, xb_data[g] <= head.data, xb_dest[g] <= head.dest.
  - Non-granted lanes get xb_valid <= 0; their xb_data/xb_dest hold previous values.
- Latency: push at edge t -> head at t+1 -> xb_valid at edge t+2 when uncontended. Minimum latency 2 cycles.
- Throughput: 1 beat/cycle per input when destinations do not conflict.
- Head-of-line blocking is accepted: a blocked head stalls its whole FIFO.
- Simultaneous push and pop on a non-full FIFO: count unchanged; both take effect.
- FIFO pointers wrap modulo DEPTH. Count width is $clog2(DEPTH+1).
- Invariant: every asserted xb_valid pair has distinct xb_dest values.
- Out-of-range s_dest (>= N_OUT when N_OUT is not a power of 2): the beat is dropped at push; s_ready behaves normally.
- Reset mid-operation: all FIFO contents are discarded, and xb_valid drops asynchronously.

Optional Feature:
- Macro: DTT_SCHED_STATS_EN.
- Defined:
  - stall_cnt[i] increments on each cycle with s_valid[i] && !s_ready[i] while rst_n is high.
  - 16-bit, saturates at 0xFFFF, cleared only by reset.
- Undefined: stall_cnt[i] is tied to 0 and no counter logic is generated. Ports are identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with s_valid=1 on all lanes -> all xb_valid=0, xb_data=0, xb_dest=0, s_ready=0. After release, s_ready=1 on all lanes.
- Single beat: input 0 pushes data 0xA5A5_0001, dest 2 at edge t -> xb_valid[0]=1, xb_data[0]=0xA5A5_0001, xb_dest[0]=2 after edge t+2 only. Other lanes stay 0.
- Permutation: inputs 0..3 push dests 3,2,1,0 in the same cycle -> all four xb_valid=1 together two edges later, with matching dests.
- Full conflict: inputs 0..3 each push one beat to dest 1 in the same cycle -> exactly one xb_valid per cycle, granted in order 0,1,2,3 on 4 consecutive cycles. rr_ptr[1] ends at 0.
- Backpressure (DEPTH=4, stats enabled):
  - Stimulus: input 3 pushes continuously to dest 0 while inputs 0..2 also stream to dest 0.
  - Input 3 receives every 4th grant and its FIFO fills; s_ready[3]=0 once count=4.
  - stall_cnt[3] counts the stalled cycles exactly.
- Mid-operation reset: with FIFOs half full, pulse rst_n low between edges -> xb_valid clears immediately. After release, no previously queued beat ever appears.
